// File: rtl/prog_loader.sv
// Program loader: streams a host byte image into the unified memory, pads the rest
// with NOP bytes, and only then releases the core.
module prog_loader #(
   parameter int         DEPTH    = 64,
   parameter int         ADDR_W   = 6,
   parameter logic [7:0] PAD_BYTE = 8'h00
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   input  logic              s_last,
   output logic              s_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              core_run,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   byte_count,
   output logic [7:0]        checksum
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LOAD  = 3'd1;
   localparam logic [2:0] PAD   = 3'd2;
   localparam logic [2:0] FLUSH = 3'd3;
   localparam logic [2:0] RUN   = 3'd4;
   localparam logic [2:0] ERR   = 3'd5;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              run_q, run_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [7:0]        sum_q, sum_d;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      case (state_q)
         IDLE, RUN, ERR: begin
            if (start) begin
               state_d = LOAD;
               ptr_d   = '0;
               cnt_d   = '0;
               sum_d   = '0;
            end
         end
         LOAD: begin
            if (s_valid) begin
               we_d    = 1'b1;
               addr_d  = ptr_q;
               wdata_d = s_data;
               ptr_d   = ptr_q + ADDR_W'(1);
               cnt_d   = cnt_q + (ADDR_W + 1)'(1);
               sum_d   = sum_q + s_data;
               if (s_last) begin
                  state_d = (ptr_q == LAST_ADDR) ? FLUSH : PAD;
               end else if (ptr_q == LAST_ADDR) begin
                  state_d = ERR;
               end
            end
         end
         PAD: begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = PAD_BYTE;
            ptr_d   = ptr_q + ADDR_W'(1);
            if (ptr_q == LAST_ADDR) begin
               state_d = FLUSH;
            end
         end
         FLUSH: state_d = RUN;
         default: state_d = IDLE;
      endcase
      // Core release lags RUN entry by one edge but drops on the restart edge itself.
      run_d = (state_q == RUN) && !start;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         run_q   <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         run_q   <= run_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
      end
   end

   assign s_ready    = (state_q == LOAD);
   assign err        = (state_q == ERR);
   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign core_run   = run_q;
   assign done       = run_q;
   assign byte_count = cnt_q;
   assign checksum   = sum_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: per-cycle behavioural model plus image-level checks.
module tb_prog_loader;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       start = 1'b0;
   logic       s_valid = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic       s_last = 1'b0;
   logic       s_ready, mem_we, core_run, done, err;
   logic [5:0] mem_addr;
   logic [7:0] mem_wdata, checksum;
   logic [6:0] byte_count;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] tb_mem [64];

   prog_loader #(.DEPTH(64), .ADDR_W(6), .PAD_BYTE(8'h00)) dut (
      .CLK(CLK), .RST(RST), .start(start), .s_valid(s_valid), .s_data(s_data),
      .s_last(s_last), .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .core_run(core_run), .done(done), .err(err),
      .byte_count(byte_count), .checksum(checksum)
   );

   always #5 CLK = ~CLK;

   // Memory behind the write port
   always @(posedge CLK) begin
      if (mem_we === 1'b1) tb_mem[mem_addr] <= mem_wdata;
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: phase of the load plus expected registered outputs
   localparam int P_IDLE = 0, P_LOAD = 1, P_PAD = 2, P_FLUSH = 3, P_RUN = 4, P_ERR = 5;
   int m_phase, m_ptr, m_cnt, m_sum, e_addr, e_wdata;
   bit e_we, e_run;

   task automatic model_reset();
      m_phase = P_IDLE; m_ptr = 0; m_cnt = 0; m_sum = 0;
      e_we = 0; e_addr = 0; e_wdata = 0; e_run = 0;
   endtask

   task automatic model_step(input bit st, input bit v, input logic [7:0] d, input bit l);
      bit was_run;
      was_run = (m_phase == P_RUN);
      e_we = 0;
      case (m_phase)
         P_IDLE, P_RUN, P_ERR:
            if (st) begin m_phase = P_LOAD; m_ptr = 0; m_cnt = 0; m_sum = 0; end
         P_LOAD:
            if (v) begin
               e_we = 1; e_addr = m_ptr; e_wdata = int'(d);
               m_cnt++; m_sum = (m_sum + int'(d)) % 256;
               if (l) m_phase = (m_ptr == 63) ? P_FLUSH : P_PAD;
               else if (m_ptr == 63) m_phase = P_ERR;
               m_ptr++;
            end
         P_PAD: begin
            e_we = 1; e_addr = m_ptr; e_wdata = 0;
            if (m_ptr == 63) m_phase = P_FLUSH;
            m_ptr++;
         end
         P_FLUSH: m_phase = P_RUN;
         default: ;
      endcase
      e_run = was_run && !st;
   endtask

   // Compare process: inputs change only just after negedge, so at negedge they are
   // exactly what the preceding rising edge sampled.
   initial begin
      model_reset();
      forever begin
         @(negedge CLK);
         if (!RST) model_reset();
         else model_step(start, s_valid, s_data, s_last);
         chk("s_ready", int'(s_ready), int'(m_phase == P_LOAD));
         chk("err", int'(err), int'(m_phase == P_ERR));
         chk("mem_we", int'(mem_we), int'(e_we));
         chk("core_run", int'(core_run), int'(e_run));
         chk("done", int'(done), int'(e_run));
         chk("byte_count", int'(byte_count), m_cnt);
         chk("checksum", int'(checksum), m_sum);
         if (e_we || !RST) begin
            chk("mem_addr", int'(mem_addr), e_addr);
            chk("mem_wdata", int'(mem_wdata), e_wdata);
         end
      end
   end

   task automatic drive(input bit st, input bit v, input logic [7:0] d, input bit l);
      @(negedge CLK); #1;
      start = st; s_valid = v; s_data = d; s_last = l;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 8'($urandom), 1'($urandom));
   endtask

   // stall: 0 none, 1 one idle cycle before every byte, 2 random stalls with ignored start pulses
   task automatic send(input logic [7:0] q[$], input bit with_last, input int stall);
      for (int i = 0; i < q.size(); i++) begin
         if (stall == 1) idle(1);
         if (stall == 2)
            while ($urandom_range(0, 2) == 0)
               drive(1'($urandom_range(0, 3) == 0), 1'b0, 8'($urandom), 1'($urandom));
         drive(1'b0, 1'b1, q[i], with_last && (i == q.size() - 1));
      end
   endtask

   // Edges counted from the last accepting edge until core_run is seen high
   task automatic wait_run(input int exp_n, input string nm);
      int n;
      n = -1;
      for (int k = 0; k < 200; k++) begin
         idle(1);
         if (core_run === 1'b1) begin n = k; break; end
      end
      chk(nm, n, exp_n);
   endtask

   task automatic check_mem(input logic [7:0] q[$], input string nm);
      int bad;
      logic [7:0] exp;
      bad = -1;
      for (int i = 0; i < 64; i++) begin
         exp = (i < q.size()) ? q[i] : 8'h00;
         if (tb_mem[i] !== exp && bad < 0) bad = i;
      end
      chk({nm, " first wrong address"}, bad, -1);
   endtask

   function automatic int sum_of(input logic [7:0] q[$]);
      int s;
      s = 0;
      foreach (q[i]) s = (s + int'(q[i])) % 256;
      return s;
   endfunction

   initial begin
      logic [7:0] img[$];
      logic [7:0] full[$];
      int len;
      bit wl;
      for (int i = 0; i < 64; i++) tb_mem[i] = 8'hAA;

      #1 RST = 1'b0;
      #1;
      chk("reset s_ready", int'(s_ready), 0);
      chk("reset mem_we", int'(mem_we), 0);
      chk("reset core_run", int'(core_run), 0);
      chk("reset byte_count", int'(byte_count), 0);
      idle(3);
      RST = 1'b1;
      idle(2);

      // Four-byte image, no stalls
      img = '{8'h05, 8'h03, 8'h01, 8'h06};
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      send(img, 1'b1, 0);
      wait_run(62, "A core_run latency");
      check_mem(img, "A memory");
      chk("A byte_count", int'(byte_count), 4);
      chk("A checksum", int'(checksum), 8'h0F);
      chk("A done", int'(done), 1);

      // Same image, s_valid every other cycle
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      send(img, 1'b1, 1);
      wait_run(62, "B core_run latency");
      check_mem(img, "B memory");
      chk("B checksum", int'(checksum), 8'h0F);

      // Full 64-byte image
      full = {};
      for (int i = 0; i < 64; i++) full.push_back(8'($urandom));
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      send(full, 1'b1, 0);
      wait_run(2, "C core_run latency");
      check_mem(full, "C memory");
      chk("C byte_count", int'(byte_count), 64);
      chk("C checksum", int'(checksum), sum_of(full));
      chk("C err", int'(err), 0);

      // Restart from RUN
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      chk("E core_run after start", int'(core_run), 0);
      img = '{8'h0C, 8'h00};
      send(img, 1'b1, 0);
      wait_run(64, "E core_run latency");
      check_mem(img, "E memory");
      chk("E checksum", int'(checksum), 8'h0C);

      // Overflow: 64 bytes with no s_last
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      send(full, 1'b0, 0);
      drive(1'b0, 1'b1, 8'h5A, 1'b1);
      chk("D err", int'(err), 1);
      chk("D s_ready", int'(s_ready), 0);
      chk("D core_run", int'(core_run), 0);
      idle(2);
      chk("D byte_count after 65th", int'(byte_count), 64);

      // Reset in the middle of padding
      img = '{8'h11, 8'h22, 8'h33};
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      send(img, 1'b1, 0);
      idle(10);
      @(negedge CLK); #3;
      RST = 1'b0;
      #1;
      chk("F reset mem_we", int'(mem_we), 0);
      chk("F reset mem_addr", int'(mem_addr), 0);
      chk("F reset mem_wdata", int'(mem_wdata), 0);
      chk("F reset checksum", int'(checksum), 0);
      chk("F reset byte_count", int'(byte_count), 0);
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      chk("F start ignored in reset", int'(s_ready), 0);
      @(negedge CLK); #1;
      RST = 1'b1;
      img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      send(img, 1'b1, 0);
      wait_run(61, "F fresh load latency");
      check_mem(img, "F memory");

      // Randomized images with random stalls and ignored start pulses
      for (int it = 0; it < 8; it++) begin
         len = $urandom_range(1, 64);
         wl  = (len < 64) ? 1'b1 : 1'($urandom);
         img = {};
         for (int i = 0; i < len; i++) img.push_back(8'($urandom));
         drive(1'b1, 1'b0, 8'h00, 1'b0);
         send(img, wl, 2);
         if (wl) begin
            wait_run(66 - len, "R core_run latency");
            check_mem(img, "R memory");
         end else begin
            idle(3);
            chk("R overflow err", int'(err), 1);
         end
         chk("R checksum", int'(checksum), sum_of(img));
         chk("R byte_count", int'(byte_count), len);
      end

      idle(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

endmodule
